eq_clockgen: RTL and testbench

//  Parametrised 6809-style quadrature clock generator (E/Q) with free-running MHZ24/MHZ12 taps.

---
 rtl/eq_clockgen_pkg.sv | 29 ++
 rtl/eq_clockgen_quarter_divider.sv | 40 ++++
 rtl/eq_clockgen.sv | 111 +++++++++++
 tb/tb_eq_clockgen.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eq_clockgen_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// eq_clockgen_pkg -- phase encoding and default sizing for the E/Q generator.
// Revision 1.0
// ----------------------------------------------------------------------------
package eq_clockgen_pkg;

  localparam int unsigned QDIV_DEFAULT   = 4;
  localparam int unsigned MAXSTR_DEFAULT = 40;

  typedef enum logic [2:0] {
    PH_Q0   = 3'd0,
    PH_Q1   = 3'd1,
    PH_Q2   = 3'd2,
    PH_Q3   = 3'd3,
    PH_HOLD = 3'd4
  } phase_e;

  // HOLD is an extension of Q3: E stays high, Q stays low.
  function automatic logic phase_e_level(input phase_e ph);
    return (ph == PH_Q2) || (ph == PH_Q3) || (ph == PH_HOLD);
  endfunction

  function automatic logic phase_q_level(input phase_e ph);
    return (ph == PH_Q1) || (ph == PH_Q2);
  endfunction

endpackage
`default_nettype wire

// File: rtl/eq_clockgen_quarter_divider.sv
`default_nettype none
// ----------------------------------------------------------------------------
// eq_clockgen_quarter_divider -- quarter-phase counter with latched SLOW select.
// Revision 1.0
// ----------------------------------------------------------------------------
module eq_clockgen_quarter_divider
  import eq_clockgen_pkg::*;
#(
  parameter int unsigned QDIV = QDIV_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic slow_i,
  input  logic load_i,
  output logic tick_o
);

  localparam int unsigned CW = $clog2(2 * QDIV);

  logic [CW-1:0] qcnt_q, qcnt_d, term;
  logic          slow_q, slow_d;

  assign term   = slow_q ? CW'(2 * QDIV - 1) : CW'(QDIV - 1);
  assign tick_o = (qcnt_q == term);
  assign qcnt_d = tick_o ? '0 : qcnt_q + CW'(1);
  // SLOW only takes effect from the quarter that opens a new bus cycle.
  assign slow_d = load_i ? slow_i : slow_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      qcnt_q <= '0;
      slow_q <= 1'b0;
    end else begin
      qcnt_q <= qcnt_d;
      slow_q <= slow_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/eq_clockgen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// eq_clockgen -- 6809-style E/Q generator with wait states, nWAIT stretch, SLOW mode.
// Revision 1.0
// ----------------------------------------------------------------------------
module eq_clockgen
  import eq_clockgen_pkg::*;
#(
  parameter int unsigned QDIV   = QDIV_DEFAULT,
  parameter int unsigned WS_W   = 3,
  parameter int unsigned MAXSTR = MAXSTR_DEFAULT
) (
  input  logic            MHZ48,
  input  logic            RESET,
  input  logic            nWAIT,
  input  logic [WS_W-1:0] WS,
  input  logic            SLOW,
  output logic            MHZ24,
  output logic            MHZ12,
  output logic            nQ,
  output logic            nE,
  output logic            E_RISE,
  output logic            E_FALL,
  output logic            STRETCHED
);

  localparam int unsigned SC_W = $clog2(MAXSTR + 1) + 1;

  phase_e          phase_q, phase_d;
  logic [WS_W-1:0] ws_left_q, ws_left_d, ws_dec;
  logic [SC_W-1:0] strcnt_q, strcnt_d;
  logic [1:0]      div_q;
  logic            ne_q, nq_q, e_rise_q, e_fall_q, stretched_q;
  logic            tick, enter_q0;

  eq_clockgen_quarter_divider #(.QDIV(QDIV)) u_qdiv (
    .clk_i  (MHZ48),
    .rst_i  (RESET),
    .slow_i (SLOW),
    .load_i (enter_q0),
    .tick_o (tick)
  );

  assign ws_dec   = (ws_left_q != '0) ? ws_left_q - WS_W'(1) : ws_left_q;
  assign enter_q0 = tick && (phase_d == PH_Q0);

  always_comb begin
    phase_d   = phase_q;
    ws_left_d = ws_left_q;
    strcnt_d  = strcnt_q;
    if (tick) begin
      unique case (phase_q)
        PH_Q0: phase_d = PH_Q1;
        PH_Q1: phase_d = PH_Q2;
        PH_Q2: phase_d = PH_Q3;
        PH_Q3: begin
          if (!nWAIT || (ws_left_q != '0)) begin
            phase_d  = PH_HOLD;
            strcnt_d = SC_W'(1);
          end else begin
            phase_d = PH_Q0;
          end
        end
        PH_HOLD: begin
          // strcnt_q numbers the HOLD quarter now ending; MAXSTR caps a stuck nWAIT.
          ws_left_d = ws_dec;
          strcnt_d  = strcnt_q + SC_W'(1);
          if (((ws_dec == '0) && nWAIT) || (strcnt_q == SC_W'(MAXSTR)))
            phase_d = PH_Q0;
        end
        default: phase_d = PH_Q0;
      endcase
    end
    if (enter_q0)
      ws_left_d = WS;
  end

  always_ff @(posedge MHZ48) begin
    if (RESET) begin
      phase_q     <= PH_Q0;
      ws_left_q   <= '0;
      strcnt_q    <= '0;
      div_q       <= '0;
      ne_q        <= 1'b1;
      nq_q        <= 1'b1;
      e_rise_q    <= 1'b0;
      e_fall_q    <= 1'b0;
      stretched_q <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      ws_left_q   <= ws_left_d;
      strcnt_q    <= strcnt_d;
      div_q       <= div_q + 2'd1;
      ne_q        <= ~phase_e_level(phase_d);
      nq_q        <= ~phase_q_level(phase_d);
      e_rise_q    <= tick && (phase_q == PH_Q1);
      e_fall_q    <= enter_q0;
      stretched_q <= (phase_d == PH_HOLD);
    end
  end

  assign MHZ24     = div_q[0];
  assign MHZ12     = div_q[1];
  assign nE        = ne_q;
  assign nQ        = nq_q;
  assign E_RISE    = e_rise_q;
  assign E_FALL    = e_fall_q;
  assign STRETCHED = stretched_q;

endmodule
`default_nettype wire

// File: tb/tb_eq_clockgen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_eq_clockgen -- directed scenarios plus randomized run against a quarter-level model.
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_eq_clockgen;

  localparam int QDIV   = 4;
  localparam int WS_W   = 3;
  localparam int MAXSTR = 40;

  logic            MHZ48 = 1'b0;
  logic            RESET = 1'b1;
  logic            nWAIT = 1'b1;
  logic            SLOW  = 1'b0;
  logic [WS_W-1:0] WS    = '0;
  logic            MHZ24, MHZ12, nQ, nE, E_RISE, E_FALL, STRETCHED;

  int n_cmp = 0;
  int n_bad = 0;

  eq_clockgen #(.QDIV(QDIV), .WS_W(WS_W), .MAXSTR(MAXSTR)) dut (
    .MHZ48     (MHZ48),
    .RESET     (RESET),
    .nWAIT     (nWAIT),
    .WS        (WS),
    .SLOW      (SLOW),
    .MHZ24     (MHZ24),
    .MHZ12     (MHZ12),
    .nQ        (nQ),
    .nE        (nE),
    .E_RISE    (E_RISE),
    .E_FALL    (E_FALL),
    .STRETCHED (STRETCHED)
  );

  always #10 MHZ48 = ~MHZ48;

  // Reference model: quarter index (0..3, 4 = stretched), cycles into quarter,
  // quarter length, owed wait quarters and the number of the current stretch quarter.
  int m_quarter, m_pos, m_len, m_ws, m_hold, m_free;
  bit m_rise, m_fall;

  always @(posedge MHZ48) begin
    bit to_q0;
    to_q0 = 1'b0;
    if (RESET) begin
      m_quarter = 0; m_pos = 0; m_len = QDIV; m_ws = 0; m_hold = 0;
      m_free = 0; m_rise = 1'b0; m_fall = 1'b0;
    end else begin
      m_free = (m_free + 1) % 4;
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (m_pos < m_len - 1) begin
        m_pos++;
      end else begin
        m_pos = 0;
        if (m_quarter < 3) begin
          m_quarter++;
          m_rise = (m_quarter == 2);
        end else if (m_quarter == 3) begin
          if (!nWAIT || m_ws > 0) begin m_quarter = 4; m_hold = 1; end
          else to_q0 = 1'b1;
        end else begin
          if (m_ws > 0) m_ws--;
          if ((m_ws == 0 && nWAIT) || m_hold == MAXSTR) to_q0 = 1'b1;
          else m_hold++;
        end
        if (to_q0) begin
          m_quarter = 0;
          m_fall    = 1'b1;
          m_len     = SLOW ? 2 * QDIV : QDIV;
          m_ws      = int'(WS);
        end
      end
    end
  end

  function automatic logic [6:0] model_out();
    logic [1:0] f;
    f = m_free[1:0];
    return {f[0], f[1], !(m_quarter == 1 || m_quarter == 2), !(m_quarter >= 2),
            m_rise, m_fall, (m_quarter == 4)};
  endfunction

  function automatic logic [6:0] dut_out();
    return {MHZ24, MHZ12, nQ, nE, E_RISE, E_FALL, STRETCHED};
  endfunction

  // Measurement helpers (no checking): -1 marks an expired cycle budget.
  task automatic wait_q0(output int w);
    w = 0;
    do begin @(negedge MHZ48); w++; end while (E_FALL !== 1'b1 && w < 2000);
    if (E_FALL !== 1'b1) w = -1;
  endtask

  task automatic measure_period(output int p);
    p = 0;
    do begin @(negedge MHZ48); p++; end while (E_FALL !== 1'b1 && p < 2000);
    if (E_FALL !== 1'b1) p = -1;
  endtask

  task automatic measure_high(output int hi, output int st, output int fl);
    int guard;
    hi = 0; st = 0; fl = 0; guard = 0;
    while (nE !== 1'b0 && guard < 2000) begin @(negedge MHZ48); guard++; end
    while (nE === 1'b0 && guard < 2000) begin
      hi++;
      if (STRETCHED === 1'b1) st++;
      if (E_FALL === 1'b1) fl++;
      @(negedge MHZ48);
      guard++;
    end
    if (E_FALL === 1'b1) fl++;
    if (guard >= 2000) hi = -1;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    repeat (3) @(negedge MHZ48);
    n_cmp++;
    if (dut_out() !== 7'b0011000) begin
      n_bad++; $display("FAIL reset_state: got %b expected %b", dut_out(), 7'b0011000);
    end
    RESET = 1'b0;
    @(negedge MHZ48);
    n_cmp++;
    if (dut_out() !== 7'b1011000) begin
      n_bad++; $display("FAIL first_cycle: got %b expected %b", dut_out(), 7'b1011000);
    end
  endtask

  task automatic test_basic_timing();
    int ne_f[$], ne_r[$], nq_f[$], m12_r[$], m24_r[$];
    logic pe, pq, p12, p24;
    int strobe_err, v;
    pe = nE; pq = nQ; p12 = MHZ12; p24 = MHZ24; strobe_err = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge MHZ48);
      if (pe && !nE) ne_f.push_back(c);
      if (!pe && nE) ne_r.push_back(c);
      if (pq && !nQ) nq_f.push_back(c);
      if (!p12 && MHZ12) m12_r.push_back(c);
      if (!p24 && MHZ24) m24_r.push_back(c);
      if (E_RISE !== (pe && !nE) || E_FALL !== (!pe && nE)) strobe_err++;
      pe = nE; pq = nQ; p12 = MHZ12; p24 = MHZ24;
    end
    v = (ne_f.size() >= 2) ? ne_f[1] - ne_f[0] : -1;
    n_cmp++; if (v !== 16) begin n_bad++; $display("FAIL e_period: got %0d expected 16", v); end
    v = (ne_f.size() >= 1 && ne_r.size() >= 1) ? ne_r[0] - ne_f[0] : -1;
    n_cmp++; if (v !== 8) begin n_bad++; $display("FAIL e_high: got %0d expected 8", v); end
    v = (ne_f.size() >= 2 && ne_r.size() >= 1) ? ne_f[1] - ne_r[0] : -1;
    n_cmp++; if (v !== 8) begin n_bad++; $display("FAIL e_low: got %0d expected 8", v); end
    v = (ne_f.size() >= 1 && nq_f.size() >= 1) ? ne_f[0] - nq_f[0] : -1;
    n_cmp++; if (v !== 4) begin n_bad++; $display("FAIL q_lead: got %0d expected 4", v); end
    v = (m12_r.size() >= 2) ? m12_r[1] - m12_r[0] : -1;
    n_cmp++; if (v !== 4) begin n_bad++; $display("FAIL mhz12_period: got %0d expected 4", v); end
    v = (m24_r.size() >= 2) ? m24_r[1] - m24_r[0] : -1;
    n_cmp++; if (v !== 2) begin n_bad++; $display("FAIL mhz24_period: got %0d expected 2", v); end
    n_cmp++; if (strobe_err !== 0) begin n_bad++; $display("FAIL edge_strobes: got %0d bad cycles expected 0", strobe_err); end
  endtask

  task automatic test_wait_states();
    int w, hi, st, fl;
    wait_q0(w);
    n_cmp++; if (w < 0) begin n_bad++; $display("FAIL ws_sync: got %0d expected >=0", w); end
    WS = 3'd2;
    measure_high(hi, st, fl);
    n_cmp++; if (hi !== 8) begin n_bad++; $display("FAIL ws_not_yet: got %0d expected 8", hi); end
    WS = 3'd0;
    measure_high(hi, st, fl);
    n_cmp++; if (hi !== 16) begin n_bad++; $display("FAIL ws2_high: got %0d expected 16", hi); end
    n_cmp++; if (st !== 8) begin n_bad++; $display("FAIL ws2_stretch: got %0d expected 8", st); end
    measure_high(hi, st, fl);
    n_cmp++; if (hi !== 8 || st !== 0) begin n_bad++; $display("FAIL ws0_after: got %0d/%0d expected 8/0", hi, st); end
  endtask

  task automatic test_nwait_stretch();
    int w, hi, st, fl;
    wait_q0(w);
    w = 0;
    while (nE !== 1'b0 && w < 100) begin @(negedge MHZ48); w++; end
    nWAIT = 1'b0;
    fork
      begin repeat (50) @(negedge MHZ48); nWAIT = 1'b1; end
      measure_high(hi, st, fl);
    join
    n_cmp++; if (hi !== 52) begin n_bad++; $display("FAIL nwait_high: got %0d expected 52", hi); end
    n_cmp++; if (st !== 44) begin n_bad++; $display("FAIL nwait_stretch: got %0d expected 44", st); end
    n_cmp++; if (fl !== 1) begin n_bad++; $display("FAIL nwait_efall: got %0d pulses expected 1", fl); end
    @(negedge MHZ48);
    n_cmp++; if (E_FALL !== 1'b0) begin n_bad++; $display("FAIL efall_single: got %b expected 0", E_FALL); end
  endtask

  task automatic test_maxstr();
    int w, hi, st, fl;
    wait_q0(w);
    nWAIT = 1'b0;
    measure_high(hi, st, fl);
    n_cmp++; if (hi !== 168 || st !== 160) begin n_bad++; $display("FAIL maxstr_first: got %0d/%0d expected 168/160", hi, st); end
    measure_high(hi, st, fl);
    n_cmp++; if (hi !== 168 || st !== 160) begin n_bad++; $display("FAIL maxstr_reenter: got %0d/%0d expected 168/160", hi, st); end
    nWAIT = 1'b1;
  endtask

  task automatic test_slow();
    int w, p;
    wait_q0(w);
    repeat (6) @(negedge MHZ48);
    SLOW = 1'b1;
    measure_period(p);
    n_cmp++; if (p + 6 !== 16) begin n_bad++; $display("FAIL slow_current: got %0d expected 16", p + 6); end
    measure_period(p);
    n_cmp++; if (p !== 32) begin n_bad++; $display("FAIL slow_next: got %0d expected 32", p); end
    repeat (6) @(negedge MHZ48);
    SLOW = 1'b0;
    measure_period(p);
    n_cmp++; if (p + 6 !== 32) begin n_bad++; $display("FAIL fast_current: got %0d expected 32", p + 6); end
    measure_period(p);
    n_cmp++; if (p !== 16) begin n_bad++; $display("FAIL fast_next: got %0d expected 16", p); end
  endtask

  task automatic test_reset_in_hold();
    int w;
    nWAIT = 1'b0;
    w = 0;
    while (STRETCHED !== 1'b1 && w < 200) begin @(negedge MHZ48); w++; end
    n_cmp++; if (STRETCHED !== 1'b1) begin n_bad++; $display("FAIL hold_reached: got %b expected 1", STRETCHED); end
    repeat (5) @(negedge MHZ48);
    RESET = 1'b1;
    @(negedge MHZ48);
    n_cmp++;
    if (dut_out() !== 7'b0011000) begin
      n_bad++; $display("FAIL reset_in_hold: got %b expected %b", dut_out(), 7'b0011000);
    end
    nWAIT = 1'b1;
    RESET = 1'b0;
  endtask

  task automatic test_random();
    int errs, first_bad;
    errs = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge MHZ48);
      n_cmp++;
      if (dut_out() !== model_out()) begin
        n_bad++; errs++;
        if (errs <= 20)
          $display("FAIL random_cycle_%0d: got %b expected %b", c, dut_out(), model_out());
      end
      if ($urandom_range(19) == 0) nWAIT = ~nWAIT;
      if ($urandom_range(29) == 0) WS = WS_W'($urandom_range(7));
      if ($urandom_range(199) == 0) SLOW = ~SLOW;
    end
    first_bad = errs;
    nWAIT = 1'b1; WS = '0; SLOW = 1'b0;
    if (first_bad > 20) $display("random run: %0d further differing cycles not listed", first_bad - 20);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_timing();
    test_wait_states();
    test_nwait_stretch();
    test_maxstr();
    test_slow();
    test_reset_in_hold();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
